// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch-bounce emulator.
package bounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; reloads the seed on reset.
module lfsr16
    import bounce_pkg::*;
(
    input  logic        CLK50M,
    input  logic        RST_N,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] value_r;

    // Advance one step every clock so the sequence depends only on time since reset.
    always_ff @(posedge CLK50M or negedge RST_N) begin
        if (!RST_N) begin
            value_r <= seed;
        end else begin
            value_r <= lfsr_next(value_r);
        end
    end

    assign value = value_r;

endmodule

// File: rtl/bounce_gen.sv
// Mechanical-switch bounce emulator: each accepted level change of A is
// reproduced on A_noisy as 1+2P edges with random spacing, then held stable.
module bounce_gen
    import bounce_pkg::*;
#(
    parameter int          PAIR_W     = 2,
    parameter int          GAP_W      = 4,
    parameter int          SETTLE_CYC = 100,
    parameter logic [15:0] SEED       = DEFAULT_SEED
) (
    input  logic       CLK50M,
    input  logic       RST_N,
    input  logic       A,
    input  logic       en,
    output logic       A_noisy,
    output logic       busy,
    output logic [7:0] xfer_cnt
);

    localparam int EDGE_W = PAIR_W + 1;
    localparam int GAP_CW = GAP_W + 1;
    localparam int SET_W  = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC);

    state_t              state_r, state_s;
    logic                noisy_r, noisy_s;
    logic                busy_r;
    logic [7:0]          xfer_r, xfer_s, xfer_inc_s;
    logic                target_r, target_s;
    logic [EDGE_W-1:0]   edges_r, edges_s;
    logic [GAP_CW-1:0]   gap_r, gap_s, new_gap_s;
    logic [SET_W-1:0]    settle_r, settle_s;
    logic [PAIR_W-1:0]   pairs_s;
    logic [15:0]         lfsr_s;
    logic                lfsr_unused_s;

    lfsr16 u_lfsr (
        .CLK50M (CLK50M),
        .RST_N  (RST_N),
        .seed   (SEED),
        .value  (lfsr_s)
    );

    // Only the low (pair count) and high (gap) slices are consumed.
    assign lfsr_unused_s = ^lfsr_s;
    assign pairs_s       = lfsr_s[PAIR_W-1:0];
    assign new_gap_s     = {1'b0, lfsr_s[15:16-GAP_W]} + GAP_CW'(1);
    assign xfer_inc_s    = (xfer_r == 8'hFF) ? xfer_r : (xfer_r + 8'd1);

    // Next-state and next-value logic for the FSM, counters and output level.
    always_comb begin
        state_s  = state_r;
        noisy_s  = noisy_r;
        xfer_s   = xfer_r;
        target_s = target_r;
        edges_s  = edges_r;
        gap_s    = gap_r;
        settle_s = settle_r;
        case (state_r)
            IDLE: begin
                if (A != noisy_r) begin
                    noisy_s = A;
                    xfer_s  = xfer_inc_s;
                    if (en) begin
                        target_s = A;
                        edges_s  = {pairs_s, 1'b0};
                        gap_s    = new_gap_s;
                        if (pairs_s != {PAIR_W{1'b0}}) begin
                            state_s = BOUNCE;
                        end else begin
                            state_s  = SETTLE;
                            settle_s = SETTLE_LOAD;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BOUNCE: begin
                if (gap_r == GAP_CW'(1)) begin
                    noisy_s = ~noisy_r;
                    edges_s = edges_r - EDGE_W'(1);
                    gap_s   = new_gap_s;
                    // Last bounce edge: level is back at target after an even number of toggles.
                    if (edges_r == EDGE_W'(1)) begin
                        state_s  = SETTLE;
                        settle_s = SETTLE_LOAD;
                    end else begin
                        state_s = BOUNCE;
                    end
                end else begin
                    gap_s = gap_r - GAP_CW'(1);
                end
            end
            SETTLE: begin
                if (settle_r <= SET_W'(1)) begin
                    state_s  = IDLE;
                    settle_s = {SET_W{1'b0}};
                end else begin
                    settle_s = settle_r - SET_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any sequence in flight.
    always_ff @(posedge CLK50M or negedge RST_N) begin
        if (!RST_N) begin
            state_r  <= IDLE;
            noisy_r  <= 1'b0;
            busy_r   <= 1'b0;
            xfer_r   <= 8'd0;
            target_r <= 1'b0;
            edges_r  <= {EDGE_W{1'b0}};
            gap_r    <= {GAP_CW{1'b0}};
            settle_r <= {SET_W{1'b0}};
        end else begin
            state_r  <= state_s;
            noisy_r  <= noisy_s;
            busy_r   <= (state_s != IDLE);
            xfer_r   <= xfer_s;
            target_r <= target_s;
            edges_r  <= edges_s;
            gap_r    <= gap_s;
            settle_r <= settle_s;
        end
    end

    assign A_noisy  = noisy_r;
    assign busy     = busy_r;
    assign xfer_cnt = xfer_r;

endmodule

// File: tb/tb_bounce_gen.sv
// Directed/random-timed bench for bounce_gen with an edge-time reference model.
module tb_bounce_gen;

    localparam int          PW     = 2;
    localparam int          GW     = 4;
    localparam int          SC     = 100;
    localparam logic [15:0] SEED_V = 16'hACE1;

    logic       CLK50M;
    logic       RST_N;
    logic       A;
    logic       en;
    logic       A_noisy;
    logic       busy;
    logic [7:0] xfer_cnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] m_lfsr;
    int          last_edges[$];
    int          ref_edges[$];

    bounce_gen #(
        .PAIR_W     (PW),
        .GAP_W      (GW),
        .SETTLE_CYC (SC),
        .SEED       (SEED_V)
    ) dut (
        .CLK50M   (CLK50M),
        .RST_N    (RST_N),
        .A        (A),
        .en       (en),
        .A_noisy  (A_noisy),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
    );

    // 50 MHz clock.
    initial begin
        CLK50M = 1'b0;
        forever #10 CLK50M = ~CLK50M;
    end

    // LFSR value n clocks after value x (polynomial x^16+x^14+x^13+x^11+1).
    function automatic logic [15:0] lfsr_adv(input logic [15:0] x, input int n);
        logic [15:0] v;
        v = x;
        for (int i = 0; i < n; i++) begin
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; m_lfsr then holds the value the DUT will use at the next edge.
    task automatic tick();
        @(posedge CLK50M);
        #1;
        m_lfsr = lfsr_adv(m_lfsr, 1);
    endtask

    task automatic do_reset(input logic a_lvl, input logic en_lvl);
        RST_N = 1'b0;
        A     = a_lvl;
        en    = en_lvl;
        repeat (3) tick();
        RST_N  = 1'b1;
        m_lfsr = SEED_V;
    endtask

    // Drive A to lvl before the next edge and check the full edge train.
    // flip_at >= 1 returns A to its old level before that clock (must be ignored).
    task automatic run_transition(input logic lvl, input int flip_at, input int exp_xfer);
        int          exp_t[$];
        int          obs_t[$];
        int          p;
        int          t;
        int          g;
        int          busy_fall;
        int          n;
        logic [15:0] lv;
        logic        prev;
        p = int'(m_lfsr[PW-1:0]);
        t = 0;
        exp_t.push_back(0);
        for (int i = 0; i < 2 * p; i++) begin
            lv = lfsr_adv(m_lfsr, t);
            g  = 1 + int'(lv[15:16-GW]);
            t  = t + g;
            exp_t.push_back(t);
        end
        prev      = A_noisy;
        A         = lvl;
        busy_fall = -1;
        for (int c = 0; c < 400 && busy_fall < 0; c++) begin
            if (c == flip_at) A = ~lvl;
            tick();
            if (A_noisy !== prev) obs_t.push_back(c);
            prev = A_noisy;
            if (c == 0) begin
                chk("busy_on_start", {31'd0, busy}, 32'd1);
                chk("xfer_on_start", {24'd0, xfer_cnt}, exp_xfer);
            end else if (busy === 1'b0) begin
                busy_fall = c;
            end
        end
        n = obs_t.size();
        chk("busy_fall_seen", {31'd0, busy_fall >= 0}, 32'd1);
        chk("edge_count", n, exp_t.size());
        chk("edge_count_odd", n % 2, 32'd1);
        chk("edge_count_max7", {31'd0, n <= 7}, 32'd1);
        chk("first_edge_at_sample", (n > 0) ? obs_t[0] : -1, 32'd0);
        for (int i = 0; i < n && i < exp_t.size(); i++) begin
            chk("edge_time", obs_t[i], exp_t[i]);
            if (i > 0) begin
                g = obs_t[i] - obs_t[i-1];
                chk("gap_range", {31'd0, (g >= 1) && (g <= 16)}, 32'd1);
            end
        end
        chk("final_level", {31'd0, A_noisy}, {31'd0, lvl});
        if (n > 0) chk("settle_len", busy_fall - obs_t[n-1], SC);
        last_edges = obs_t;
    endtask

    // Directed scenario sequence.
    initial begin
        // Reset held with A=1: outputs cleared, LFSR at seed.
        RST_N  = 1'b0;
        A      = 1'b1;
        en     = 1'b0;
        m_lfsr = SEED_V;
        repeat (3) tick();
        chk("rst_A_noisy", {31'd0, A_noisy}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_xfer", {24'd0, xfer_cnt}, 32'd0);
        chk("rst_lfsr", {16'd0, dut.u_lfsr.value}, 32'h0000ACE1);

        // Bypass: A_noisy follows A on the sampling edge, never busy.
        A      = 1'b0;
        RST_N  = 1'b1;
        m_lfsr = SEED_V;
        repeat (2) tick();
        A = 1'b1;
        tick();
        chk("byp_A_noisy", {31'd0, A_noisy}, 32'd1);
        chk("byp_busy", {31'd0, busy}, 32'd0);
        chk("byp_xfer", {24'd0, xfer_cnt}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("byp_busy_hold", {31'd0, busy}, 32'd0);
        end
        A = 1'b0;
        tick();
        chk("byp_fall", {31'd0, A_noisy}, 32'd0);
        chk("byp_xfer2", {24'd0, xfer_cnt}, 32'd2);

        // Bounce from reset with A=1 already present at release.
        do_reset(1'b1, 1'b1);
        run_transition(1'b1, -1, 1);
        ref_edges = last_edges;

        // Ignored input: A pulses back low during the sequence, then 1->0 starts after IDLE.
        do_reset(1'b0, 1'b1);
        repeat (2) tick();
        run_transition(1'b1, 3, 1);
        run_transition(1'b0, -1, 2);

        // Mid-sequence reset: immediate clear, then identical replay.
        do_reset(1'b1, 1'b1);
        repeat (3) tick();
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        chk("mid_noisy_before", {31'd0, A_noisy}, 32'd1);
        #5;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_A_noisy", {31'd0, A_noisy}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_xfer", {24'd0, xfer_cnt}, 32'd0);
        repeat (2) tick();
        RST_N  = 1'b1;
        m_lfsr = SEED_V;
        run_transition(1'b1, -1, 1);
        chk("replay_count", last_edges.size(), ref_edges.size());
        for (int i = 0; i < last_edges.size() && i < ref_edges.size(); i++) begin
            chk("replay_edge", last_edges[i], ref_edges[i]);
        end

        // Saturation: 300 bypass transitions stop at 255.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            A = ~A;
            tick();
            if (i == 253) chk("sat_254", {24'd0, xfer_cnt}, 32'd254);
            if (i == 254) chk("sat_255", {24'd0, xfer_cnt}, 32'd255);
        end
        chk("sat_final", {24'd0, xfer_cnt}, 32'd255);
        chk("sat_follow", {31'd0, A_noisy}, {31'd0, A});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
